// File: rtl/rca8_word_sched.sv
// Round-robin two-requester scheduler over one shared 8-bit ripple-carry slice, LSB byte first.
// Result valid WORDS cycles after accept; req*_ready stays low until the response is taken.

module rca8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [8:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[8];
   end
endmodule

module rca8_word_sched #(
   parameter  int WORDS = 4,
   localparam int W     = 8 * WORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_cin,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_cin,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_sum,
   output logic         resp_cout,
   output logic         resp_id
);
   localparam int            KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t                 state, state_nxt;
   logic                   last;
   logic [KW-1:0]          k;
   logic                   carry;
   logic [WORDS-1:0][7:0]  a_reg, b_reg, sum_reg;
   logic                   grant0, grant1, accept;
   logic [7:0]             slice_sum;
   logic                   slice_cout;

   rca8 u_slice (
      .a    (a_reg[k]),
      .b    (b_reg[k]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // On a tie the requester not granted last time wins.
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               grant0 = req0_valid && (!req1_valid || last);
               grant1 = req1_valid && (!req0_valid || !last);
               if (grant0 || grant1) state_nxt = ADD;
            end
         end
         ADD:     if (k == K_LAST) state_nxt = DONE;
         DONE:    if (resp_ready)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 | grant1;
   assign resp_valid = (state == DONE);
   assign resp_sum   = sum_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         k         <= '0;
         carry     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         resp_cout <= 1'b0;
         resp_id   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg   <= grant1 ? req1_a   : req0_a;
            b_reg   <= grant1 ? req1_b   : req0_b;
            carry   <= grant1 ? req1_cin : req0_cin;
            resp_id <= grant1;
            last    <= grant1;
            k       <= '0;
         end
         if (state == ADD) begin
            sum_reg[k] <= slice_sum;
            carry      <= slice_cout;
            k          <= k + 1'b1;
            if (k == K_LAST) resp_cout <= slice_cout;
         end
      end
   end
endmodule

// File: tb/tb_rca8_word_sched.sv
// Randomized and directed bench for rca8_word_sched against a transaction-level reference model.
module tb_rca8_word_sched;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_cin = 1'b0, req1_cin = 1'b0;
   logic         resp_valid;
   logic         resp_ready = 1'b1;
   logic [W-1:0] resp_sum;
   logic         resp_cout, resp_id;

   always #5 clk = ~clk;

   rca8_word_sched #(.WORDS(WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: one outstanding add; result = a+b+cin, visible WORDS cycles after acceptance.
   bit           m_busy  = 1'b0;
   bit           m_last  = 1'b1;
   bit           m_fresh = 1'b0;
   int           m_cnt   = 0;
   logic [W-1:0] m_sum   = '0;
   logic         m_cout  = 1'b0;
   logic         m_id    = 1'b0;

   always @(negedge clk) begin : model_blk
      bit         e0, e1, ev;
      logic [W:0] full;
      e0 = !rst && !m_busy && req0_valid && (!req1_valid || m_last);
      e1 = !rst && !m_busy && req1_valid && (!req0_valid || !m_last);
      ev = m_busy && (m_cnt >= WORDS);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("resp_valid", resp_valid, ev);
      if (ev) begin
         chk("resp_sum",  resp_sum,  m_sum);
         chk("resp_cout", resp_cout, m_cout);
         chk("resp_id",   resp_id,   m_id);
      end
      if (m_fresh) begin
         chk("rst_sum",  resp_sum,  0);
         chk("rst_cout", resp_cout, 0);
         chk("rst_id",   resp_id,   0);
      end
      if (rst) begin
         m_busy  = 1'b0;
         m_last  = 1'b1;
         m_cnt   = 0;
         m_fresh = 1'b1;
      end else if (e0 || e1) begin
         if (e1) full = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
         else    full = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
         m_sum   = full[W-1:0];
         m_cout  = full[W];
         m_id    = e1;
         m_last  = e1;
         m_busy  = 1'b1;
         m_cnt   = 0;
         m_fresh = 1'b0;
      end else if (m_busy) begin
         if (ev) begin
            if (resp_ready) m_busy = 1'b0;
         end else begin
            m_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit p, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      bit acc = 1'b0;
      int guard = 0;
      if (p) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
      else   begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
      while (!acc && guard < 60) begin
         @(negedge clk);
         acc = p ? req1_ready : req0_ready;
         guard++;
         tick();
      end
      if (p) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_resp(input string tag, input logic [W-1:0] s, input logic c, input logic id);
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            chk({tag, "_sum"},  resp_sum,  s);
            chk({tag, "_cout"}, resp_cout, c);
            chk({tag, "_id"},   resp_id,   id);
         end
         tick();
      end
      if (!got) chk({tag, "_timeout"}, 0, 1);
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] cs [4];
      logic         cc [4];
      logic         ci [4];
      int           n;
      bit           a0, a1, seen;

      // Reset: outputs at reset values, ready gated even with a valid request
      req1_valid = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_valid",  resp_valid, 0);
      tick();
      req1_valid = 1'b0;
      rst = 1'b0;

      send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      wait_resp("single", 32'h0000_0100, 1'b0, 1'b0);

      send(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_resp("ripple", 32'h0000_0000, 1'b1, 1'b1);

      // Contention: both held valid, grants must alternate starting with req0
      cs = '{32'h2345_6789, 32'h0000_0000, 32'h2345_6789, 32'h0000_0000};
      cc = '{1'b0, 1'b1, 1'b0, 1'b1};
      ci = '{1'b0, 1'b1, 1'b0, 1'b1};
      req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0;
      req1_a = 32'h8000_0000; req1_b = 32'h8000_0000; req1_cin = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            chk("cont_sum",  resp_sum,  cs[n]);
            chk("cont_cout", resp_cout, cc[n]);
            chk("cont_id",   resp_id,   ci[n]);
            n++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (n < 4) chk("cont_timeout", n, 4);

      // Backpressure with req1 pending behind the stalled response
      resp_ready = 1'b0;
      req1_a = 32'd5; req1_b = 32'd6; req1_cin = 1'b0; req1_valid = 1'b1;
      send(0, 32'h0A0B_0C0D, 32'h0101_0101, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = resp_valid;
         tick();
      end
      if (!seen) chk("bp_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",  resp_valid, 1);
         chk("bp_sum",    resp_sum,   32'h0B0C_0D0E);
         chk("bp_cout",   resp_cout,  0);
         chk("bp_id",     resp_id,    0);
         chk("bp_ready0", req0_ready, 0);
         chk("bp_ready1", req1_ready, 0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      send(1, 32'd5, 32'd6, 1'b0);
      wait_resp("bp_r1", 32'd11, 1'b0, 1'b1);

      // Reset while the byte index is 2
      send(0, 32'h0000_0055, 32'h0000_0066, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_valid", resp_valid, 0);
         chk("abort_sum",   resp_sum,   0);
         tick();
      end
      send(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
      wait_resp("post_rst", 32'h0000_0002, 1'b0, 1'b0);

      // Operand change the cycle after accept must not leak in
      send(0, 32'h0000_0010, 32'h0000_0020, 1'b1);
      req0_a = 32'hFFFF_FFFF;
      req0_b = 32'hFFFF_FFFF;
      wait_resp("opchg", 32'h0000_0031, 1'b0, 1'b0);

      // Randomized traffic, backpressure and occasional reset
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         tick();
         if (!req0_valid || a0) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom_range(0, 1));
         end
         if (!req1_valid || a1) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom_range(0, 1));
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b1;
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
